// File: rtl/ln_bwd_scheduler.sv
// rtl/ln_bwd_scheduler.sv - per-row handshake sequencer for the layer-norm backward unit
// Walks a tile row by row (fetch, launch, wait, write dX, release) and sums dgamma/dbeta with saturation.
module ln_bwd_scheduler #(
  parameter int IL      = 4,
  parameter int FL      = 16,
  parameter int ROWS_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [ROWS_W-1:0]    num_rows_i,
  input  logic                 abort_i,
  output logic                 row_req_o,
  output logic [ROWS_W-1:0]    row_idx_o,
  input  logic                 row_valid_i,
  output logic                 bwd_input_ready_o,
  output logic                 bwd_output_taken_o,
  input  logic [1:0]           bwd_state_i,
  input  logic [IL+FL-1:0]     bwd_dgamma_i,
  input  logic [IL+FL-1:0]     bwd_dbeta_i,
  output logic                 dx_we_o,
  input  logic                 dx_ack_i,
  output logic [IL+FL-1:0]     dgamma_acc_o,
  output logic [IL+FL-1:0]     dbeta_acc_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o
);

  localparam int W     = IL + FL;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [W-1:0]     SAT_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]     SAT_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_LAUNCH  = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_RELEASE = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  localparam logic [1:0] UNIT_IDLE = 2'b00;
  localparam logic [1:0] UNIT_HELD = 2'b10;

  logic [2:0]        state_q, state_d;
  logic [ROWS_W-1:0] num_rows_q, num_rows_d;
  logic [ROWS_W-1:0] row_idx_q, row_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      dgamma_q, dgamma_d;
  logic [W-1:0]      dbeta_q, dbeta_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;
  logic              taken_q, taken_d;
  logic              abort_now;
  logic              last_row;

  // Sign-extend by one bit; a disagreement between the top two sum bits means overflow.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {a[W-1], a} + {b[W-1], b};
    if (s[W] != s[W-1]) sat_add = s[W] ? SAT_MIN : SAT_MAX;
    else                sat_add = s[W-1:0];
  endfunction

  assign abort_now = abort_q | abort_i;
  assign last_row  = (row_idx_q == num_rows_q - ROWS_W'(1));

  always_comb begin
    state_d    = state_q;
    num_rows_d = num_rows_q;
    row_idx_d  = row_idx_q;
    cnt_d      = cnt_q;
    dgamma_d   = dgamma_q;
    dbeta_d    = dbeta_q;
    abort_d    = abort_q;
    err_d      = err_q;
    taken_d    = taken_q;

    if (state_q != S_IDLE && abort_i) abort_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          num_rows_d = num_rows_i;
          row_idx_d  = '0;
          dgamma_d   = '0;
          dbeta_d    = '0;
          err_d      = 1'b0;
          abort_d    = 1'b0;
          state_d    = (num_rows_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        if (row_valid_i && bwd_state_i == UNIT_IDLE) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bwd_state_i == UNIT_HELD) begin
          state_d = S_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WRITE: begin
        if (dx_ack_i) begin
          dgamma_d = sat_add(dgamma_q, bwd_dgamma_i);
          dbeta_d  = sat_add(dbeta_q, bwd_dbeta_i);
          state_d  = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // taken_q limits the release strobe to the first RELEASE cycle.
        taken_d = 1'b1;
        if (bwd_state_i == UNIT_IDLE) begin
          taken_d = 1'b0;
          if (last_row || abort_now) begin
            err_d   = err_q | abort_now;
            state_d = S_DONE;
          end else begin
            row_idx_d = row_idx_q + ROWS_W'(1);
            state_d   = S_FETCH;
          end
        end
      end
      S_DONE: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q    <= S_IDLE;
      num_rows_q <= '0;
      row_idx_q  <= '0;
      cnt_q      <= '0;
      dgamma_q   <= '0;
      dbeta_q    <= '0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      taken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_rows_q <= num_rows_d;
      row_idx_q  <= row_idx_d;
      cnt_q      <= cnt_d;
      dgamma_q   <= dgamma_d;
      dbeta_q    <= dbeta_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
      taken_q    <= taken_d;
    end
  end

  assign row_req_o          = (state_q == S_FETCH);
  assign row_idx_o          = row_idx_q;
  assign bwd_input_ready_o  = (state_q == S_LAUNCH);
  assign bwd_output_taken_o = (state_q == S_RELEASE) && !taken_q;
  assign dx_we_o            = (state_q == S_WRITE);
  assign dgamma_acc_o       = dgamma_q;
  assign dbeta_acc_o        = dbeta_q;
  assign busy_o             = (state_q != S_IDLE);
  assign done_o             = (state_q == S_DONE);
  assign err_o              = err_q;

endmodule

// File: tb/tb_ln_bwd_scheduler.sv
// tb/tb_ln_bwd_scheduler.sv - bench for ln_bwd_scheduler with behavioural unit/buffer models
module tb_ln_bwd_scheduler;
  localparam int IL = 4, FL = 16, ROWS_W = 8, TIMEOUT = 1024;
  localparam int W = IL + FL;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));

  logic clk = 1'b0;
  logic reset_i, start_i, abort_i, row_valid_i, dx_ack_i;
  logic [ROWS_W-1:0] num_rows_i;
  logic [1:0] bwd_state_i;
  logic [W-1:0] bwd_dgamma_i, bwd_dbeta_i;
  logic row_req_o, bwd_input_ready_o, bwd_output_taken_o, dx_we_o, busy_o, done_o, err_o;
  logic [ROWS_W-1:0] row_idx_o;
  logic [W-1:0] dgamma_acc_o, dbeta_acc_o;

  ln_bwd_scheduler #(.IL(IL), .FL(FL), .ROWS_W(ROWS_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .num_rows_i(num_rows_i), .abort_i(abort_i),
    .row_req_o(row_req_o), .row_idx_o(row_idx_o), .row_valid_i(row_valid_i),
    .bwd_input_ready_o(bwd_input_ready_o), .bwd_output_taken_o(bwd_output_taken_o),
    .bwd_state_i(bwd_state_i), .bwd_dgamma_i(bwd_dgamma_i), .bwd_dbeta_i(bwd_dbeta_i),
    .dx_we_o(dx_we_o), .dx_ack_i(dx_ack_i), .dgamma_acc_o(dgamma_acc_o), .dbeta_acc_o(dbeta_acc_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  int dg_tab[16], db_tab[16];
  int max_dly = 0, max_lat = 0, abort_row = -1, hang_row = -1;
  bit ack_hold = 0;
  int us = 0, u_cnt = 0, cur_row = 0, rv_wait = 0, ack_wait = 0;
  int cyc = 0, launch_cnt, taken_cnt, write_cnt, done_cnt, req_cnt, order_bad, we_bad;
  int launch_cyc, taken_cyc, err_at_done, idx_at_done;
  bit prev_we = 0;

  function automatic int sat(input int a, input int b);
    int s;
    s = a + b;
    if (s > SMAX) return SMAX;
    if (s < SMIN) return SMIN;
    return s;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Backward unit: 00 idle, 01 busy for a random latency (or forever on hang_row), 10 holding results.
  always @(negedge clk) begin
    if (!reset_i) begin
      us = 0; bwd_state_i = 2'b00;
    end else begin
      case (us)
        0: if (bwd_input_ready_o) begin
             cur_row = int'(row_idx_o); us = 1; bwd_state_i = 2'b01; u_cnt = $urandom_range(0, max_lat);
           end
        1: if (bwd_output_taken_o) begin us = 3; u_cnt = $urandom_range(0, 2); end
           else if (cur_row != hang_row) begin
             if (u_cnt == 0) begin
               us = 2; bwd_state_i = 2'b10;
               bwd_dgamma_i = W'(dg_tab[cur_row]); bwd_dbeta_i = W'(db_tab[cur_row]);
             end else u_cnt--;
           end
        2: if (bwd_output_taken_o) begin us = 3; u_cnt = $urandom_range(0, 2); end
        default: if (u_cnt == 0) begin us = 0; bwd_state_i = 2'b00; end else u_cnt--;
      endcase
    end
    if (us != 2) begin bwd_dgamma_i = W'($urandom); bwd_dbeta_i = W'($urandom); end
  end

  // Activation buffer: row_valid after a random delay (noise outside fetch), dx_ack after a random delay.
  always @(negedge clk) begin
    if (row_req_o) begin
      if (rv_wait == 0) row_valid_i = 1'b1; else begin rv_wait--; row_valid_i = 1'b0; end
    end else begin
      row_valid_i = 1'($urandom_range(0, 1)); rv_wait = $urandom_range(0, max_dly);
    end
    if (dx_we_o && !ack_hold) begin
      if (ack_wait == 0) dx_ack_i = 1'b1; else begin ack_wait--; dx_ack_i = 1'b0; end
    end else begin
      dx_ack_i = 1'b0; ack_wait = $urandom_range(0, max_dly);
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (bwd_input_ready_o) begin
      if (int'(row_idx_o) != launch_cnt) order_bad++;
      launch_cnt++; launch_cyc = cyc;
      if (int'(row_idx_o) == abort_row) abort_i = 1'b1;
    end
    if (bwd_output_taken_o) begin taken_cnt++; taken_cyc = cyc; end
    if (prev_we && !dx_we_o) write_cnt++;
    if (dx_we_o && bwd_state_i != 2'b10) we_bad++;
    if (row_req_o) req_cnt++;
    if (done_o) begin done_cnt++; err_at_done = int'(err_o); idx_at_done = int'(row_idx_o); end
    prev_we = dx_we_o;
  end

  task automatic run_tile(input string tag, input int n, input bit inject);
    int proc, written, eg, eb, last;
    bit exp_err, seen;
    proc = (abort_row >= 0 && abort_row < n) ? abort_row + 1 : n;
    exp_err = (abort_row >= 0 && abort_row < n) || (hang_row >= 0 && hang_row < proc);
    written = 0; eg = 0; eb = 0;
    for (int r = 0; r < proc; r++)
      if (r != hang_row) begin eg = sat(eg, dg_tab[r]); eb = sat(eb, db_tab[r]); written++; end
    last = (proc > 0) ? proc - 1 : 0;
    launch_cnt = 0; taken_cnt = 0; write_cnt = 0; done_cnt = 0; req_cnt = 0; order_bad = 0; we_bad = 0;
    start_i = 1'b1; num_rows_i = ROWS_W'(n);
    @(negedge clk);
    start_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 4000 && !seen; c++) begin
      if (done_o) seen = 1;
      else begin
        if (inject && c == 3 && busy_o) begin start_i = 1'b1; num_rows_i = ROWS_W'(n + 3); end
        @(negedge clk);
        start_i = 1'b0; num_rows_i = ROWS_W'(n);
      end
    end
    abort_row = -1; abort_i = 1'b0;
    check({tag, "_done_seen"}, int'(seen), 1);
    repeat (2) @(negedge clk);
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_err"}, err_at_done, int'(exp_err));
    check({tag, "_launches"}, launch_cnt, proc);
    check({tag, "_releases"}, taken_cnt, proc);
    check({tag, "_writes"}, write_cnt, written);
    check({tag, "_row_idx"}, idx_at_done, last);
    check({tag, "_dgamma"}, int'($signed(dgamma_acc_o)), eg);
    check({tag, "_dbeta"}, int'($signed(dbeta_acc_o)), eb);
    check({tag, "_row_req_seen"}, int'(req_cnt > 0), int'(proc > 0));
    check({tag, "_launch_order"}, order_bad, 0);
    check({tag, "_we_only_when_held"}, we_bad, 0);
    check({tag, "_busy_after"}, int'(busy_o), 0);
  endtask

  initial begin
    bit seen;
    reset_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; num_rows_i = '0;
    row_valid_i = 1'b0; dx_ack_i = 1'b0; bwd_state_i = 2'b00; bwd_dgamma_i = '0; bwd_dbeta_i = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy_o), 0);
    check("rst_done", int'(done_o), 0);
    check("rst_err", int'(err_o), 0);
    check("rst_row_req", int'(row_req_o), 0);
    check("rst_row_idx", int'(row_idx_o), 0);
    check("rst_dx_we", int'(dx_we_o), 0);
    check("rst_dgamma", int'(dgamma_acc_o), 0);
    check("rst_dbeta", int'(dbeta_acc_o), 0);
    reset_i = 1'b1;
    @(negedge clk);

    // abort pulsed while idle must not leak into the next tile
    abort_i = 1'b1; repeat (3) @(negedge clk); abort_i = 1'b0;
    check("idle_abort_busy", int'(busy_o), 0);
    for (int r = 0; r < 3; r++) begin dg_tab[r] = 'h10000; db_tab[r] = -'h8000; end
    run_tile("t1", 3, 1'b0);
    check("t1_dgamma_const", int'(dgamma_acc_o), 'h30000);
    check("t1_dbeta_const", int'($signed(dbeta_acc_o)), -'h18000);

    // empty tile: done exactly one cycle after start
    start_i = 1'b1; num_rows_i = '0; launch_cnt = 0; req_cnt = 0;
    @(negedge clk);
    start_i = 1'b0;
    check("t2_done_next", int'(done_o), 1);
    check("t2_err", int'(err_o), 0);
    @(negedge clk);
    check("t2_done_pulse", int'(done_o), 0);
    check("t2_no_launch", launch_cnt, 0);
    check("t2_no_req", req_cnt, 0);

    max_dly = 3; max_lat = 5;
    dg_tab[0] = SMAX; dg_tab[1] = SMAX; db_tab[0] = SMIN; db_tab[1] = SMIN;
    run_tile("t3_sat", 2, 1'b0);

    for (int r = 0; r < 5; r++) begin
      dg_tab[r] = int'($urandom_range(0, 'h3FFF)); db_tab[r] = -int'($urandom_range(0, 'h3FFF));
    end
    abort_row = 1;
    run_tile("t4_abort", 5, 1'b0);

    hang_row = 0; dg_tab[0] = 'h1234;
    run_tile("t5_timeout", 1, 1'b0);
    check("t5_wait_len", taken_cyc - launch_cyc, TIMEOUT + 1);
    hang_row = -1;

    for (int t = 0; t < 5; t++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int r = 0; r < n; r++) begin
        dg_tab[r] = int'($urandom_range(0, (1 << W) - 1)) + SMIN;
        db_tab[r] = int'($urandom_range(0, (1 << W) - 1)) + SMIN;
      end
      run_tile($sformatf("rnd%0d", t), n, 1'b1);
    end

    // reset while row 2 is waiting for its dX acknowledge
    for (int r = 0; r < 4; r++) begin dg_tab[r] = 'h100; db_tab[r] = 'h200; end
    start_i = 1'b1; num_rows_i = ROWS_W'(4);
    @(negedge clk);
    start_i = 1'b0;
    seen = 0;
    for (int c = 0; c < 500 && !seen; c++) begin
      if (row_idx_o == ROWS_W'(2)) ack_hold = 1'b1;
      if (dx_we_o && row_idx_o == ROWS_W'(2)) seen = 1;
      else @(negedge clk);
    end
    check("t6_reached_write", int'(seen), 1);
    reset_i = 1'b0; us = 0; bwd_state_i = 2'b00;
    @(negedge clk);
    check("t6_busy", int'(busy_o), 0);
    check("t6_dgamma", int'(dgamma_acc_o), 0);
    check("t6_dbeta", int'(dbeta_acc_o), 0);
    check("t6_row_idx", int'(row_idx_o), 0);
    check("t6_dx_we", int'(dx_we_o), 0);
    reset_i = 1'b1; ack_hold = 1'b0;
    @(negedge clk);
    run_tile("t6_clean", 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
